wb_queue: RTL and testbench
===========================

WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter M, default 32, meaning number of architectural registers including virtual register 0.
REQ-002 SHALL have parameter N, default 8, meaning register data width in bits.
REQ-003 SHALL have parameter DEPTH, default 4, meaning queue entries; a power of two, at least 2.
REQ-004 SHALL derive localparam AW = $clog2(M) as the register-address width.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  a pending register write is offered.
REQ-008 in_ready  output  1  the queue accepts the offered write this cycle.
REQ-009 in_rd  input  AW  destination register address of the offered write.
REQ-010 in_data  input  N  write data of the offered write.
REQ-011 rf_stall  input  1  register-file write port unavailable this cycle.
REQ-012 rf_w_enable  output  1  register-file write strobe.
REQ-013 rf_rd  output  AW  register-file write address.
REQ-014 rf_wdata  output  N  register-file write data.
REQ-015 lookup_addr  input  AW  forwarding query address.
REQ-016 lookup_hit  output  1  a pending write to lookup_addr exists.
REQ-017 lookup_data  output  N  data of the youngest pending write to lookup_addr.
REQ-018 count  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-019 full, empty  output  1 each  occupancy flags.

Function
REQ-020 Push SHALL occur when in_valid && in_ready; pop SHALL occur when !empty && !rf_stall.
REQ-021 in_ready SHALL equal !full || pop, so push and pop in the same cycle at full are allowed.
REQ-022 A push with in_rd == 0 SHALL be accepted and discarded, leaving count unchanged.
REQ-023 rf_w_enable SHALL equal pop; rf_rd and rf_wdata SHALL combinationally present the head entry, or 0 when empty.
REQ-024 Minimum latency SHALL be one cycle: an entry pushed in cycle t is first visible on the rf_* ports in cycle t+1.
REQ-025 Entries SHALL drain in strict FIFO order; read and write pointers SHALL wrap modulo DEPTH.
REQ-026 count SHALL update by +1 on push only, by -1 on pop only, and stay unchanged on simultaneous push and pop.
REQ-027 full SHALL equal (count == DEPTH) and empty SHALL equal (count == 0), both registered-consistent with count.
REQ-028 lookup_hit SHALL be asserted only when lookup_addr != 0 and a valid entry matches it.
REQ-029 lookup_data SHALL carry the youngest matching entry's data, or 0 on a miss; an entry popped this cycle still counts as a hit.
REQ-030 Lookup SHALL NOT include the write being offered on in_* in the same cycle.

Reset
REQ-031 On reset, pointers and count SHALL become 0 and all entries invalid; outputs then read empty=1, full=0, in_ready=1, rf_w_enable=0, rf_rd=0, rf_wdata=0, lookup_hit=0, lookup_data=0.
REQ-032 Reset asserted mid-operation SHALL discard all pending writes, with no rf_w_enable in the reset cycle.

Configuration
REQ-033 With macro WB_QUEUE_FWD_EN defined, the forwarding lookup logic SHALL be compiled in as specified above.
REQ-034 Without WB_QUEUE_FWD_EN, lookup_hit and lookup_data SHALL be tied to 0, while the ports remain present and all other behaviour is unchanged.

Structure
REQ-035 Shared package pico_pkg SHALL hold the M/N defaults, the register-address width constant and typedef wbq_entry_t {rd, data}.
REQ-036 The youngest-match priority search SHALL be a single sub-module, wbq_fwd_match, instantiated only under WB_QUEUE_FWD_EN.

Verification
REQ-037 Reset, then push rd=5, data=0xA3 with rf_stall=0 -> next cycle rf_w_enable=1, rf_rd=5, rf_wdata=0xA3; the cycle after that, empty=1.
REQ-038 rf_stall=1, push 4 entries (rd 1..4) -> full=1, in_ready=0, count=4; a 5th push is refused; release stall -> rd 1,2,3,4 drain on 4 consecutive cycles.
REQ-039 Full queue with rf_stall=0 and in_valid=1 -> in_ready=1, count stays 4, FIFO order is preserved across pointer wrap.
REQ-040 Push rd=0, data=0xFF -> accepted, count unchanged, no rf_w_enable ever issued for it.
REQ-041 Stalled queue, push rd=7 data=0x11 then rd=7 data=0x22, lookup_addr=7 -> lookup_hit=1, lookup_data=0x22; lookup_addr=0 -> hit=0; without WB_QUEUE_FWD_EN -> hit=0 always.
REQ-042 Three entries pending, assert reset for one cycle -> empty=1 and count=0 next cycle, and no rf_w_enable afterwards.

Source files
------------

// File: rtl/pico_pkg.sv
// -----------------------------------------------------------------------------
// pico_pkg -- shared constants and types for the pico write-back path.
//   PICO_M      default number of architectural registers (r0 is virtual)
//   PICO_N      default register data width
//   PICO_AW     register-address width derived from PICO_M
//   wbq_entry_t one pending register write {rd, data}
// -----------------------------------------------------------------------------
package pico_pkg;

   localparam int PICO_M  = 32;
   localparam int PICO_N  = 8;
   localparam int PICO_AW = $clog2(PICO_M);

   typedef struct packed {
      logic [PICO_AW-1:0] rd;
      logic [PICO_N-1:0]  data;
   } wbq_entry_t;

endpackage

// File: rtl/wbq_fwd_match.sv
// -----------------------------------------------------------------------------
// wbq_fwd_match -- youngest-match search over the write-back queue entries.
//   valid_i  per-slot live flag
//   rd_i     per-slot destination register
//   data_i   per-slot write data
//   head_i   slot index of the oldest entry (queue read pointer)
//   addr_i   queried register address; address 0 never hits
//   hit_o    a live entry targets addr_i
//   data_o   data of the youngest such entry, 0 on a miss
// -----------------------------------------------------------------------------
module wbq_fwd_match #(
   parameter  int AW    = 5,
   parameter  int N     = 8,
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0]         valid_i,
   input  logic [DEPTH-1:0][AW-1:0] rd_i,
   input  logic [DEPTH-1:0][N-1:0]  data_i,
   input  logic [PW-1:0]            head_i,
   input  logic [AW-1:0]            addr_i,
   output logic                     hit_o,
   output logic [N-1:0]             data_o
);

   logic [PW-1:0] idx;

   // Walk slots oldest to youngest starting at the head; a later match
   // overwrites an earlier one, so the youngest write wins.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch,
      // otherwise a path that skips the assignment infers a latch.
      hit_o  = 1'b0;
      data_o = '0;
      idx    = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_i + PW'(k);
         if (addr_i != '0 && valid_i[idx] && rd_i[idx] == addr_i) begin
            hit_o  = 1'b1;
            data_o = data_i[idx];
         end
      end
   end

endmodule

// File: rtl/wb_queue.sv
// -----------------------------------------------------------------------------
// wb_queue -- FIFO of pending register-file writes with optional forwarding.
//   clk, reset          single clock, synchronous active-high reset
//   in_valid/in_ready   offered write handshake; in_rd, in_data carry it
//   rf_stall            register-file write port busy this cycle
//   rf_w_enable/rf_rd/rf_wdata   head entry presented to the register file
//   lookup_addr         forwarding query; lookup_hit/lookup_data answer it
//   count, full, empty  occupancy
// Build option: define WB_QUEUE_FWD_EN to compile in the forwarding lookup;
// otherwise lookup_hit/lookup_data are tied to 0.
// -----------------------------------------------------------------------------
module wb_queue
   import pico_pkg::*;
#(
   parameter  int M     = PICO_M,
   parameter  int N     = PICO_N,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(M),
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [AW-1:0] in_rd,
   input  logic [N-1:0]  in_data,
   input  logic          rf_stall,
   output logic          rf_w_enable,
   output logic [AW-1:0] rf_rd,
   output logic [N-1:0]  rf_wdata,
   input  logic [AW-1:0] lookup_addr,
   output logic          lookup_hit,
   output logic [N-1:0]  lookup_data,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   localparam int PW = $clog2(DEPTH);

   typedef struct packed {
      logic [AW-1:0] rd;
      logic [N-1:0]  data;
   } entry_t;

   entry_t           mem_q [DEPTH];
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push, push_keep, pop;

   assign count = count_q;
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

   // Reset blocks the pop so no register-file write escapes in the reset cycle.
   assign pop      = !empty && !rf_stall && !reset;
   assign in_ready = !full || pop;
   assign push     = in_valid && in_ready;
   // Writes to r0 are handshaken but never stored.
   assign push_keep = push && (in_rd != '0);

   assign rf_w_enable = pop;
   assign rf_rd       = empty ? '0 : mem_q[rd_ptr_q].rd;
   assign rf_wdata    = empty ? '0 : mem_q[rd_ptr_q].data;

   // Pop clears before push sets, so a same-slot push at full stays valid.
   always_comb begin
      valid_d  = valid_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CW'(push_keep) - CW'(pop);
      if (pop) begin
         valid_d[rd_ptr_q] = 1'b0;
         rd_ptr_d          = rd_ptr_q + PW'(1);
      end
      if (push_keep) begin
         valid_d[wr_ptr_q] = 1'b1;
         wr_ptr_d          = wr_ptr_q + PW'(1);
      end
   end

   // NOTE: state registers use non-blocking '<=' so every flop samples the
   // pre-edge values; blocking '=' stays in the combinational block above.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         valid_q  <= valid_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: the entry storage is deliberately not reset; valid_q and the
   // pointers decide what is live, and stale contents are never observed.
   always_ff @(posedge clk) begin
      if (push_keep) begin
         mem_q[wr_ptr_q] <= '{rd: in_rd, data: in_data};
      end
   end

`ifdef WB_QUEUE_FWD_EN
   logic [DEPTH-1:0][AW-1:0] ent_rd;
   logic [DEPTH-1:0][N-1:0]  ent_data;

   for (genvar i = 0; i < DEPTH; i++) begin : g_flat
      assign ent_rd[i]   = mem_q[i].rd;
      assign ent_data[i] = mem_q[i].data;
   end

   wbq_fwd_match #(
      .AW    (AW),
      .N     (N),
      .DEPTH (DEPTH)
   ) u_fwd (
      .valid_i (valid_q),
      .rd_i    (ent_rd),
      .data_i  (ent_data),
      .head_i  (rd_ptr_q),
      .addr_i  (lookup_addr),
      .hit_o   (lookup_hit),
      .data_o  (lookup_data)
   );
`else
   logic unused_fwd;
   assign unused_fwd  = ^{lookup_addr, valid_q};
   assign lookup_hit  = 1'b0;
   assign lookup_data = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// -----------------------------------------------------------------------------
// tb_wb_queue -- directed and random stimulus against a queue-based model of
// the write-back queue. Inputs change on the falling edge and outputs are
// compared 1 ns later; the model advances once per cycle.
// -----------------------------------------------------------------------------
module tb_wb_queue;

   localparam int AW    = 5;
   localparam int N     = 8;
   localparam int DEPTH = 4;
   localparam int CW    = 3;

`ifdef WB_QUEUE_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic          clk;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] in_rd;
   logic [N-1:0]  in_data;
   logic          rf_stall;
   logic          rf_w_enable;
   logic [AW-1:0] rf_rd;
   logic [N-1:0]  rf_wdata;
   logic [AW-1:0] lookup_addr;
   logic          lookup_hit;
   logic [N-1:0]  lookup_data;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;

   wb_queue #(.M(32), .N(N), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_rd       (in_rd),
      .in_data     (in_data),
      .rf_stall    (rf_stall),
      .rf_w_enable (rf_w_enable),
      .rf_rd       (rf_rd),
      .rf_wdata    (rf_wdata),
      .lookup_addr (lookup_addr),
      .lookup_hit  (lookup_hit),
      .lookup_data (lookup_data),
      .count       (count),
      .full        (full),
      .empty       (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] rd;
      logic [N-1:0]  data;
   } ent_t;

   ent_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   step_no = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s @step %0d: observed=0x%0h expected=0x%0h", tag, step_no, obs, exp);
      end
   endtask

   // One clock cycle: drive, compare against the model, advance the model.
   task automatic step(input bit v, input logic [AW-1:0] rd, input logic [N-1:0] d,
                       input bit st, input logic [AW-1:0] la, input bit rst);
      bit            e_pop, e_ready, e_hit;
      logic [N-1:0]  e_ld;
      logic [AW-1:0] e_rd;
      logic [N-1:0]  e_wd;
      @(negedge clk);
      step_no++;
      reset = rst; in_valid = v; in_rd = rd; in_data = d; rf_stall = st; lookup_addr = la;
      #1;
      e_pop   = !rst && (q.size() > 0) && !st;
      e_ready = (q.size() < DEPTH) || e_pop;
      e_rd    = (q.size() > 0) ? q[0].rd : '0;
      e_wd    = (q.size() > 0) ? q[0].data : '0;
      e_hit   = 1'b0;
      e_ld    = '0;
      if (FWD && la != 0) begin
         foreach (q[i]) begin
            if (q[i].rd == la) begin
               e_hit = 1'b1;
               e_ld  = q[i].data;
            end
         end
      end
      check("count",       32'(count),       32'(q.size()));
      check("empty",       32'(empty),       32'(q.size() == 0));
      check("full",        32'(full),        32'(q.size() == DEPTH));
      check("in_ready",    32'(in_ready),    32'(e_ready));
      check("rf_w_enable", 32'(rf_w_enable), 32'(e_pop));
      check("rf_rd",       32'(rf_rd),       32'(e_rd));
      check("rf_wdata",    32'(rf_wdata),    32'(e_wd));
      check("lookup_hit",  32'(lookup_hit),  32'(e_hit));
      check("lookup_data", 32'(lookup_data), 32'(e_ld));
      if (rst) begin
         q.delete();
      end else begin
         if (e_pop) void'(q.pop_front());
         if (v && e_ready && rd != 0) q.push_back('{rd: rd, data: d});
      end
      @(posedge clk);
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_rd = '0; in_data = '0;
      rf_stall = 1'b0; lookup_addr = '0;
      repeat (2) @(posedge clk);

      // Reset state, then single write with one-cycle latency.
      step(0, 0, 8'h00, 0, 0, 0);
      step(1, 5, 8'hA3, 0, 5, 0);
      step(0, 0, 8'h00, 0, 5, 0);
      step(0, 0, 8'h00, 0, 0, 0);

      // Fill while stalled, refuse a fifth, then drain in order.
      for (int i = 1; i <= 4; i++) step(1, AW'(i), N'(8'h10 + i), 1, 0, 0);
      step(1, 9, 8'h99, 1, 0, 0);
      #1;
      check("full_refuse_ready", 32'(in_ready), 32'd0);
      check("full_count", 32'(count), 32'd4);
      for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 0, 0, 0);
      step(0, 0, 8'h00, 0, 0, 0);

      // Full with simultaneous push and pop, wrapping pointers.
      for (int i = 1; i <= 4; i++) step(1, AW'(i + 10), N'(8'h40 + i), 1, 0, 0);
      for (int i = 0; i < 6; i++) step(1, AW'(i + 20), N'(8'h60 + i), 0, AW'(i + 20), 0);
      for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 0, 0, 0);

      // Writes to r0 are swallowed.
      step(1, 0, 8'hFF, 0, 0, 0);
      step(0, 0, 8'h00, 0, 0, 0);
      step(0, 0, 8'h00, 0, 0, 0);

      // Forwarding of the youngest write to r7.
      step(1, 7, 8'h11, 1, 7, 0);
      step(1, 7, 8'h22, 1, 7, 0);
      step(0, 0, 8'h00, 1, 7, 0);
      #1;
      check("fwd_hit_r7",  32'(lookup_hit),  32'(FWD));
      check("fwd_data_r7", 32'(lookup_data), FWD ? 32'h22 : 32'h0);
      step(0, 0, 8'h00, 1, 0, 0);
      step(0, 0, 8'h00, 0, 7, 0);
      step(0, 0, 8'h00, 0, 7, 0);
      step(0, 0, 8'h00, 0, 7, 0);

      // Mid-operation reset discards pending writes.
      for (int i = 1; i <= 3; i++) step(1, AW'(i + 3), N'(8'h80 + i), 1, 0, 0);
      step(0, 0, 8'h00, 0, 4, 1);
      #1;
      check("rst_count", 32'(count), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      step(0, 0, 8'h00, 0, 4, 0);
      step(0, 0, 8'h00, 0, 0, 0);

      // Random traffic with a small address set so lookups collide.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0,
              AW'($urandom_range(0, 7)),
              N'($urandom_range(0, 255)),
              $urandom_range(0, 9) < 4,
              AW'($urandom_range(0, 7)),
              $urandom_range(0, 63) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
